// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: access-size encoding,
// FSM state type and small helpers for alignment, byte lanes and store data.
package mem_stage_pkg;

  // Access size encoding as delivered by EX (3 is treated like word).
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when the low address bits suit the access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  // Byte lanes touched by an access at the given offset.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives lane-0 aligned; replicate it so every enabled lane sees it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it. Words pass through untouched.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  // Lane selection and extension; halves are always aligned so addr[1] picks the half.
  always_comb begin
    byte_sel = lane[addr];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access at a time, holds the pipeline
// until it is acknowledged, aligns load data and produces the writeback.
// Non-memory results are forwarded to writeback one cycle later.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        load_mem,
  input  logic        store_mem,
  input  logic        store_reg,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] alu_res,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_t      state_reg, state_next;
  logic        mem_op, aligned, accept, misaligned_op, alu_op;
  logic [31:0] addr_reg, wdata_reg;
  logic [1:0]  off_reg, size_reg;
  logic [3:0]  be_reg;
  logic        we_reg, unsigned_reg;
  logic [4:0]  rd_reg;
  logic        misalign_reg, wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic [31:0] load_data;

  // Decode the instruction offered by EX; it only matters while IDLE.
  always_comb begin
    mem_op        = valid_in & (load_mem | store_mem);
    aligned       = is_aligned(size, alu_res[1:0]);
    accept        = (state_reg == IDLE) & mem_op & aligned;
    misaligned_op = (state_reg == IDLE) & mem_op & ~aligned;
    alu_op        = (state_reg == IDLE) & valid_in & store_reg & ~load_mem & ~store_mem;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: one access outstanding, finished by the ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)  state_next = BUSY;
      BUSY:    if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; stall is forced low while reset is asserted.
  always_comb begin
    mem_req   = (state_reg == BUSY);
    mem_we    = mem_req & we_reg;
    mem_be    = mem_req ? be_reg : 4'b0000;
    mem_addr  = addr_reg;
    mem_wdata = wdata_reg;
    stall     = rst_n & (accept | (mem_req & ~mem_ack));
  end

  // Capture the accepted access so later EX changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      off_reg      <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      we_reg       <= 1'b0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      rd_reg       <= '0;
    end else if (accept) begin
      addr_reg     <= {alu_res[31:2], 2'b00};
      off_reg      <= alu_res[1:0];
      size_reg     <= size;
      unsigned_reg <= unsigned_ld;
      we_reg       <= store_mem;
      be_reg       <= byte_enable(size, alu_res[1:0]);
      wdata_reg    <= store_lanes(size, wdata);
      rd_reg       <= rd_in;
    end
  end

  load_align u_load_align (
    .addr        (off_reg),
    .size        (size_reg),
    .unsigned_ld (unsigned_reg),
    .rdata       (mem_rdata),
    .data        (load_data)
  );

  // Writeback and misalign pulses: each lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else begin
      misalign_reg <= misaligned_op;
      wb_valid_reg <= 1'b0;
      if (mem_req & mem_ack & ~we_reg) begin
        wb_valid_reg <= 1'b1;
        wb_rd_reg    <= rd_reg;
        wb_data_reg  <= load_data;
      end else if (alu_op) begin
        wb_valid_reg <= 1'b1;
        wb_rd_reg    <= rd_in;
        wb_data_reg  <= alu_res;
      end
    end
  end

  assign misalign = misalign_reg;
  assign wb_valid = wb_valid_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed table, hand-written reset sequences and
// random operations checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, load_mem, store_mem, store_reg, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] alu_res, wdata;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall, misalign, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .load_mem(load_mem),
    .store_mem(store_mem), .store_reg(store_reg), .size(size),
    .unsigned_ld(unsigned_ld), .alu_res(alu_res), .wdata(wdata), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .misalign(misalign),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    bit        valid, ld, st, sreg;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] alu, wdata;
    bit [4:0]  rd;
    int        waits;
    bit [31:0] rdata;
  } op_t;

  typedef struct {
    int        req_cnt, stall_cnt, wb_cnt, mis_cnt;
    bit [31:0] addr, wdata, wb_data;
    bit [3:0]  be;
    bit        we;
    bit [4:0]  wb_rd;
    bit        changed;
  } obs_t;

  typedef struct {
    op_t  op;
    obs_t exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: works on byte positions and integer arithmetic.
  function automatic obs_t model(input op_t op);
    obs_t   e;
    int     nbytes, off;
    bit     is_mem;
    longint v;
    e = '{default: 0};
    nbytes = (op.size == 2'd1) ? 1 : (op.size == 2'd2) ? 2 : 4;
    off    = int'(op.alu % 4);
    is_mem = op.valid && (op.ld || op.st);
    if (is_mem && (op.alu % nbytes) != 0) begin
      e.mis_cnt = 1;
    end else if (is_mem) begin
      e.req_cnt   = op.waits + 1;
      e.stall_cnt = op.waits + 1;
      e.addr      = op.alu - 32'(off);
      e.we        = op.st;
      for (int k = 0; k < 4; k++) begin
        e.be[k] = (k >= off) && (k < off + nbytes);
        e.wdata[8*k +: 8] = op.wdata[8*(k % nbytes) +: 8];
      end
      if (!op.st) begin
        v = (longint'(op.rdata) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
        if (!op.uns && nbytes < 4 && v >= longint'(64'd1 << (8 * nbytes - 1)))
          v = v - longint'(64'd1 << (8 * nbytes));
        e.wb_cnt  = 1;
        e.wb_data = v[31:0];
        e.wb_rd   = op.rd;
      end
    end else if (op.valid && op.sreg) begin
      e.wb_cnt  = 1;
      e.wb_data = op.alu;
      e.wb_rd   = op.rd;
    end
    return e;
  endfunction

  // Present one op at a negedge, act as memory, observe for a bounded window.
  task automatic run_op(input op_t op, output obs_t o);
    int req_seen;
    o = '{default: 0};
    req_seen = 0;
    valid_in = op.valid; load_mem = op.ld; store_mem = op.st; store_reg = op.sreg;
    size = op.size; unsigned_ld = op.uns; alu_res = op.alu; wdata = op.wdata; rd_in = op.rd;
    for (int c = 0; c < op.waits + 4; c++) begin
      if (c > 0) begin
        if (mem_req && req_seen != op.waits) begin
          // Garbage on the EX side while busy must be ignored.
          valid_in = 1'($urandom_range(1)); load_mem = 1'($urandom_range(1));
          store_mem = 1'($urandom_range(1)); store_reg = 1'($urandom_range(1));
          size = 2'($urandom_range(3)); unsigned_ld = 1'($urandom_range(1));
          alu_res = $urandom; wdata = $urandom; rd_in = 5'($urandom_range(31));
        end else begin
          valid_in = 1'b0;
        end
      end
      mem_ack   = mem_req ? (req_seen == op.waits) : 1'($urandom_range(1));
      mem_rdata = (mem_req && req_seen == op.waits) ? op.rdata : $urandom;
      #1;
      if (stall)    o.stall_cnt++;
      if (misalign) o.mis_cnt++;
      if (wb_valid) begin
        o.wb_cnt++; o.wb_data = wb_data; o.wb_rd = wb_rd;
      end
      if (mem_req) begin
        if (req_seen == 0) begin
          o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} != {o.addr, o.be, o.wdata, o.we}) begin
          o.changed = 1'b1;
        end
        req_seen++;
      end
      @(negedge clk);
    end
    o.req_cnt = req_seen;
    mem_ack = 1'b0; valid_in = 1'b0;
  endtask

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    check({tag, ".req_cycles"},   got.req_cnt,   exp.req_cnt);
    check({tag, ".stall_cycles"}, got.stall_cnt, exp.stall_cnt);
    check({tag, ".wb_count"},     got.wb_cnt,    exp.wb_cnt);
    check({tag, ".misalign"},     got.mis_cnt,   exp.mis_cnt);
    if (exp.req_cnt > 0) begin
      check({tag, ".mem_addr"},  got.addr,    exp.addr);
      check({tag, ".mem_be"},    got.be,      exp.be);
      check({tag, ".mem_we"},    got.we,      exp.we);
      check({tag, ".mem_wdata"}, got.wdata,   exp.wdata);
      check({tag, ".held"},      got.changed, 1'b0);
    end
    if (exp.wb_cnt > 0) begin
      check({tag, ".wb_data"}, got.wb_data, exp.wb_data);
      check({tag, ".wb_rd"},   got.wb_rd,   exp.wb_rd);
    end
  endtask

  vec_t  vecs [13];
  obs_t  got, exp;
  op_t   op;
  int    bad_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    //                valid ld st sreg size  uns alu           wdata         rd waits rdata
    vecs[0]  = '{'{1, 1, 0, 1, 2'd0, 0, 32'h100,      32'h0,        5'd5, 3, 32'hDEADBEEF},
                 '{4, 4, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 4'hF, 0, 5'd5, 0}};
    vecs[1]  = '{'{1, 1, 0, 1, 2'd1, 0, 32'h203,      32'h0,        5'd6, 0, 32'h80112233},
                 '{1, 1, 1, 0, 32'h200, 32'h0, 32'hFFFFFF80, 4'h8, 0, 5'd6, 0}};
    vecs[2]  = '{'{1, 1, 0, 1, 2'd1, 1, 32'h203,      32'h0,        5'd6, 0, 32'h80112233},
                 '{1, 1, 1, 0, 32'h200, 32'h0, 32'h00000080, 4'h8, 0, 5'd6, 0}};
    vecs[3]  = '{'{1, 0, 1, 0, 2'd2, 0, 32'h102,      32'h0000ABCD, 5'd1, 0, 32'h0},
                 '{1, 1, 0, 0, 32'h100, 32'hABCDABCD, 32'h0, 4'hC, 1, 5'd0, 0}};
    vecs[4]  = '{'{1, 1, 0, 1, 2'd0, 0, 32'h101,      32'h0,        5'd2, 0, 32'h0},
                 '{0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 0, 5'd0, 0}};
    vecs[5]  = '{'{1, 0, 0, 1, 2'd0, 0, 32'h55,       32'h0,        5'd7, 0, 32'h0},
                 '{0, 0, 1, 0, 32'h0, 32'h0, 32'h55, 4'h0, 0, 5'd7, 0}};
    vecs[6]  = '{'{1, 1, 1, 1, 2'd1, 0, 32'h3,        32'h12,       5'd9, 1, 32'h0},
                 '{2, 2, 0, 0, 32'h0, 32'h12121212, 32'h0, 4'h8, 1, 5'd0, 0}};
    vecs[7]  = '{'{1, 1, 0, 1, 2'd2, 0, 32'h2,        32'h0,        5'd3, 2, 32'h80010000},
                 '{3, 3, 1, 0, 32'h0, 32'h0, 32'hFFFF8001, 4'hC, 0, 5'd3, 0}};
    vecs[8]  = '{'{1, 1, 0, 1, 2'd2, 1, 32'h1002,     32'h0,        5'd4, 0, 32'h80017FFF},
                 '{1, 1, 1, 0, 32'h1000, 32'h0, 32'h00008001, 4'hC, 0, 5'd4, 0}};
    vecs[9]  = '{'{1, 0, 0, 1, 2'd0, 0, 32'hCAFEF00D, 32'h0,        5'd0, 0, 32'h0},
                 '{0, 0, 1, 0, 32'h0, 32'h0, 32'hCAFEF00D, 4'h0, 0, 5'd0, 0}};
    vecs[10] = '{'{0, 1, 0, 1, 2'd0, 0, 32'h40,       32'h0,        5'd8, 0, 32'h0},
                 '{0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 5'd0, 0}};
    vecs[11] = '{'{1, 0, 1, 0, 2'd2, 0, 32'h103,      32'h1234,     5'd0, 0, 32'h0},
                 '{0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 0, 5'd0, 0}};
    vecs[12] = '{'{1, 1, 0, 1, 2'd2, 0, 32'h0,        32'h0,        5'd31, 1, 32'h12347FFF},
                 '{2, 2, 1, 0, 32'h0, 32'h0, 32'h00007FFF, 4'h3, 0, 5'd31, 0}};

    // Reset state, with an acceptable load offered to prove stall stays low.
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    valid_in = 1'b1; load_mem = 1'b1; store_mem = 1'b0; store_reg = 1'b1;
    size = 2'd0; unsigned_ld = 1'b0; alu_res = 32'h100; wdata = 32'hFFFF_FFFF; rd_in = 5'd1;
    #12;
    check("reset.mem_req", mem_req, 1'b0);
    check("reset.mem_we", mem_we, 1'b0);
    check("reset.stall", stall, 1'b0);
    check("reset.misalign", misalign, 1'b0);
    check("reset.wb_valid", wb_valid, 1'b0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.mem_be", mem_be, 4'h0);
    check("reset.wb_data", wb_data, 32'h0);
    check("reset.wb_rd", wb_rd, 5'd0);
    $display("[TB] reset state checked");

    // Release reset and offer the first access in the same cycle.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, got);
      check_obs($sformatf("vec%0d", i), got, vecs[i].exp);
      $display("[TB] vec %0d alu=0x%08h size=%0d ld=%0d st=%0d req=%0d wb=%0d data=0x%08h",
               i, vecs[i].op.alu, vecs[i].op.size, vecs[i].op.ld, vecs[i].op.st,
               got.req_cnt, got.wb_cnt, got.wb_data);
    end

    // Reset during BUSY abandons the access.
    valid_in = 1'b1; load_mem = 1'b1; store_mem = 1'b0; store_reg = 1'b1;
    size = 2'd0; alu_res = 32'h40; rd_in = 5'd12; mem_ack = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("rstbusy.mem_req_before", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstbusy.mem_req_async", mem_req, 1'b0);
    check("rstbusy.stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_cnt = 0;
    repeat (4) begin
      mem_ack = 1'($urandom_range(1)); mem_rdata = $urandom;
      #1;
      if (wb_valid || mem_req) bad_cnt++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("rstbusy.no_activity_after", bad_cnt, 0);
    op = '{1, 1, 0, 1, 2'd1, 0, 32'h441, 32'h0, 5'd13, 1, 32'h0000F500};
    run_op(op, got);
    check_obs("rstbusy.next_load", got, model(op));
    $display("[TB] reset-during-busy sequence: post-reset activity=%0d next load data=0x%08h",
             bad_cnt, got.wb_data);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      op.valid = ($urandom_range(9) != 0);
      op.ld    = 1'($urandom_range(1));
      op.st    = 1'($urandom_range(1));
      op.sreg  = 1'($urandom_range(1));
      op.size  = 2'($urandom_range(3));
      op.uns   = 1'($urandom_range(1));
      op.alu   = $urandom;
      op.wdata = $urandom;
      op.rd    = 5'($urandom_range(31));
      op.waits = $urandom_range(3);
      op.rdata = $urandom;
      exp = model(op);
      run_op(op, got);
      check_obs($sformatf("rand%0d", i), got, exp);
      $display("[TB] rand %0d v=%0d ld=%0d st=%0d sz=%0d alu=0x%08h req=%0d mis=%0d wb=%0d data=0x%08h",
               i, op.valid, op.ld, op.st, op.size, op.alu, got.req_cnt, got.mis_cnt,
               got.wb_cnt, got.wb_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL provide EX-side inputs: valid_in 1 (slot holds a real instruction, not a bubble); load_mem 1; store_mem 1; store_reg 1; size 2 (1=byte, 2=half, 0/3=word); unsigned_ld 1 (LBU/LHU); alu_res 32 (address or result); wdata 32 (store data, lane 0 aligned); rd_in 5.
REQ-003 SHALL provide data-memory ports: mem_req out 1; mem_we out 1; mem_addr out 32 (word-aligned, [1:0]=0); mem_wdata out 32; mem_be out 4; mem_ack in 1; mem_rdata in 32.
REQ-004 SHALL provide: stall out 1 (hold EX/MEM inputs); misalign out 1 (one-cycle pulse); wb_valid out 1; wb_rd out 5; wb_data out 32.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY.
REQ-006 Accept: in IDLE, valid_in & (load_mem|store_mem) & aligned -> latch addr/data/be/size/unsigned_ld/rd; go BUSY next cycle.
REQ-007 Alignment: byte always aligned; half needs alu_res[0]=0; word needs alu_res[1:0]=0.
REQ-008 Misaligned access: no request, misalign pulses next cycle, wb_valid=0, op dropped, FSM stays IDLE.
REQ-009 In BUSY, mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata held constant until the cycle mem_ack=1 is sampled.
REQ-010 On mem_ack in BUSY, FSM returns to IDLE next cycle; ack in IDLE ignored.
REQ-011 stall=1 combinationally when (IDLE and accepting per REQ-006) or (BUSY and mem_ack=0); stall=0 in the ack cycle.
REQ-012 Byte enables: byte -> 1 << addr[1:0]; half -> 4'b0011 << addr[1:0]; word -> 4'b1111.
REQ-013 mem_wdata: byte data replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-014 Load result: lane selected by latched addr[1:0]; sign-extended unless unsigned_ld; word passes through.
REQ-015 Load writeback: cycle after ack, wb_valid=1 for exactly one cycle with wb_rd=latched rd and the extended data.
REQ-016 Store: no writeback; wb_valid=0.
REQ-017 Non-memory op: valid_in & store_reg & !load_mem & !store_mem in IDLE -> next cycle wb_valid=1, wb_data=alu_res, wb_rd=rd_in; no stall.
REQ-018 wb_rd=0 writebacks SHALL still be issued (register file ignores x0).
REQ-019 valid_in=0 SHALL produce no request, no writeback, no misalign.
REQ-020 load_mem and store_mem both high SHALL be treated as store.
REQ-021 Inputs changing while BUSY SHALL be ignored; latched values rule.

Reset
REQ-022 rst_n low SHALL immediately force IDLE; mem_req, mem_we, stall, misalign, wb_valid = 0; mem_addr, mem_wdata, wb_data = 0; mem_be = 0; wb_rd = 0.
REQ-023 Reset mid-BUSY SHALL abandon the access; no writeback after release.
REQ-024 First access SHALL be accepted in the first clock edge after rst_n deasserts.

Structure
REQ-025 Shared package SHALL hold: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-026 A combinational sub-module load_align (addr[1:0], size, unsigned_ld, rdata -> data) SHALL implement REQ-014.
REQ-027 Implementation SHALL remain synthesizable, single clock domain, no latches.

Verification
REQ-028 LW addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF -> mem_req 4 cycles, stall 4 cycles, wb_valid once with wb_data 0xDEADBEEF.
REQ-029 LB addr 0x203, rdata 0x80112233 -> mem_be 4'b1000, wb_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-030 SH addr 0x102, wdata 0x0000ABCD, immediate ack -> mem_we=1, mem_be 4'b1100, mem_wdata 0xABCDABCD, mem_addr 0x100, wb_valid=0.
REQ-031 LW addr 0x101 -> no mem_req, misalign pulse one cycle, stall=0.
REQ-032 ALU op alu_res 0x55, rd 7 -> next cycle wb_valid=1, wb_rd 7, wb_data 0x55, stall=0.
REQ-033 rst_n low during BUSY for one cycle -> mem_req drops asynchronously, no wb_valid afterwards, next load served normally.
